// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing CTRL / STATUS / DATA / SCRATCH registers.
// Read and write FSMs run independently; write strobes merge per byte lane.

module axi_lite_byte_lane #(
  parameter int LANE_W = 8
) (
  input  logic              en,
  input  logic [LANE_W-1:0] cur,
  input  logic [LANE_W-1:0] upd,
  output logic [LANE_W-1:0] merged
);
  assign merged = en ? upd : cur;
endmodule

module axi_lite_slave_regs #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [DATA_W-1:0]   status_in,
  output logic [DATA_W-1:0]   ctrl_out,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_wr_pulse
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] IDX_CTRL    = 2'd0;
  localparam logic [1:0] IDX_STATUS  = 2'd1;
  localparam logic [1:0] IDX_DATA    = 2'd2;
  localparam logic [1:0] IDX_SCRATCH = 2'd3;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // Latched write request; byte offset bits are dropped at capture.
  typedef struct packed {
    logic [ADDR_W-3:0]    word_addr;
    logic [DATA_W-1:0]    data;
    logic [NUM_LANES-1:0] strb;
  } wr_req_t;

  w_state_t w_state;
  r_state_t r_state;
  wr_req_t  wreq;
  logic     aw_lat, w_lat;

  logic [DATA_W-1:0] ctrl_q, data_q, scratch_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Write decode, evaluated on the latched request
  logic [1:0] wr_idx;
  logic       wr_in_range, commit, wr_en;

  assign wr_idx        = wreq.word_addr[1:0];
  assign wr_in_range   = (wreq.word_addr[ADDR_W-3:2] == '0);
  assign commit        = (w_state == W_IDLE) && aw_lat && w_lat;
  assign wr_en         = commit && wr_in_range && (wr_idx != IDX_STATUS);
  assign data_wr_pulse = commit && wr_in_range && (wr_idx == IDX_DATA);

  logic [DATA_W-1:0] cur_val;
  always_comb begin
    cur_val = '0;
    case (wr_idx)
      IDX_CTRL:    cur_val = ctrl_q;
      IDX_DATA:    cur_val = data_q;
      IDX_SCRATCH: cur_val = scratch_q;
      default:     cur_val = '0;
    endcase
  end

  logic [NUM_LANES-1:0][7:0] cur_lanes, upd_lanes, merged_lanes;
  assign cur_lanes = cur_val;
  assign upd_lanes = wreq.data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axi_lite_byte_lane #(.LANE_W(8)) u_lane (
      .en     (wreq.strb[i]),
      .cur    (cur_lanes[i]),
      .upd    (upd_lanes[i]),
      .merged (merged_lanes[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      data_q    <= '0;
      scratch_q <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        IDX_CTRL:    ctrl_q    <= merged_lanes;
        IDX_DATA:    data_q    <= merged_lanes;
        IDX_SCRATCH: scratch_q <= merged_lanes;
        default:     ;
      endcase
    end
  end

  assign ctrl_out = ctrl_q;
  assign data_out = data_q;

  // Write FSM: AW and W latch independently; commit when both are held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_lat  <= 1'b0;
      w_lat   <= 1'b0;
      wreq    <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_lat && w_lat) begin
            aw_lat  <= 1'b0;
            w_lat   <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
          end else begin
            if (awvalid && awready) begin
              wreq.word_addr <= awaddr[ADDR_W-1:2];
              aw_lat         <= 1'b1;
              awready        <= 1'b0;
            end else if (!aw_lat) begin
              awready <= 1'b1;
            end
            if (wvalid && wready) begin
              wreq.data <= wdata;
              wreq.strb <= wstrb;
              w_lat     <= 1'b1;
              wready    <= 1'b0;
            end else if (!w_lat) begin
              wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read mux sees pre-commit register values, so a same-cycle write is not visible.
  logic [DATA_W-1:0] rd_val;
  logic              rd_in_range;
  assign rd_in_range = (araddr[ADDR_W-1:4] == '0);

  always_comb begin
    rd_val = '0;
    if (rd_in_range) begin
      case (araddr[3:2])
        IDX_CTRL:    rd_val = ctrl_q;
        IDX_STATUS:  rd_val = status_in;
        IDX_DATA:    rd_val = data_q;
        IDX_SCRATCH: rd_val = scratch_q;
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rdata   <= rd_val;
            rresp   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboarded bench for axi_lite_slave_regs: driver pushes expected responses
// from a register-map model, a negedge monitor pops and compares on handshakes.

module tb_axi_lite_slave_regs;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, status_in = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, data_wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, ctrl_out, data_out;

  axi_lite_slave_regs #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .status_in(status_in), .ctrl_out(ctrl_out), .data_out(data_out),
    .data_wr_pulse(data_wr_pulse)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference model: register map as a plain array
  logic [31:0] m_reg [4];
  int          exp_pulses = 0;

  function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[31:4] != 0) return 2'b10;
    if (a[3:2] == 2'd1) return 2'b00;
    for (int b = 0; b < 4; b++)
      if (s[b]) m_reg[a[3:2]][8*b +: 8] = d[8*b +: 8];
    if (a[3:2] == 2'd2) exp_pulses++;
    return 2'b00;
  endfunction

  function automatic logic [33:0] m_read(input logic [31:0] a, input logic [31:0] st);
    if (a[31:4] != 0) return {2'b10, 32'h0};
    if (a[3:2] == 2'd1) return {2'b00, st};
    return {2'b00, m_reg[a[3:2]]};
  endfunction

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  // Monitor
  int          b_seen = 0, r_seen = 0, pulse_cnt = 0, pulse_cyc = 0, b_rise_cyc = 0;
  bit          b_hold = 0, r_hold = 0, bv_prev = 0;
  logic [1:0]  b_prev, r_prev_resp;
  logic [31:0] r_prev_data;
  logic [33:0] r_exp;

  always @(negedge clk) begin
    if (reset) begin
      b_hold = 0; r_hold = 0; bv_prev = 0;
    end else begin
      if (data_wr_pulse) begin pulse_cnt++; pulse_cyc = cyc; end
      if (bvalid && !bv_prev) b_rise_cyc = cyc;
      bv_prev = bvalid;
      if (b_hold) begin
        chk("bvalid_hold", bvalid, 1);
        chk("bresp_hold", bresp, b_prev);
      end
      if (bvalid) begin
        chk("aw_w_ready_in_resp", {awready, wready}, 0);
        if (bready) begin
          chk("b_expected", exp_b.size() > 0, 1);
          if (exp_b.size() > 0) chk("bresp", bresp, exp_b.pop_front());
          b_seen++; b_hold = 0;
        end else begin
          b_hold = 1; b_prev = bresp;
        end
      end else b_hold = 0;
      if (r_hold) begin
        chk("rvalid_hold", rvalid, 1);
        chk("rdata_hold", rdata, r_prev_data);
        chk("rresp_hold", rresp, r_prev_resp);
      end
      if (rvalid) begin
        chk("arready_in_rdata", arready, 0);
        if (rready) begin
          chk("r_expected", exp_r.size() > 0, 1);
          if (exp_r.size() > 0) begin
            r_exp = exp_r.pop_front();
            chk("rdata", rdata, r_exp[31:0]);
            chk("rresp", rresp, r_exp[33:32]);
          end
          r_seen++; r_hold = 0;
        end else begin
          r_hold = 1; r_prev_data = rdata; r_prev_resp = rresp;
        end
      end else r_hold = 0;
    end
  end

  // Drivers: entered and left at posedge+1
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly, input bit wait_resp);
    int aw_c, w_c, b0;
    bit aw_done, w_done, hs_aw, hs_w;
    aw_c = 0; w_c = 0; aw_done = 0; w_done = 0;
    exp_b.push_back(m_write(a, d, s));
    b0 = b_seen;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      if (!aw_done && n >= aw_dly) begin awaddr = a; awvalid = 1'b1; end
      if (!w_done && n >= w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (hs_aw) aw_c = cyc;
      if (hs_w) w_c = cyc;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w) begin w_done = 1; wvalid = 1'b0; end
    end
    chk("aw_accept", aw_done, 1);
    chk("w_accept", w_done, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    if (wait_resp) begin
      repeat (b_dly) @(posedge clk);
      #1 bready = 1'b1;
      for (int n = 0; n < 40 && b_seen == b0; n++) begin @(posedge clk); #1; end
      bready = 1'b0;
      chk("b_done", b_seen != b0, 1);
      chk("b_latency", b_rise_cyc > ((aw_c > w_c) ? aw_c : w_c), 1);
      chk("ctrl_out", ctrl_out, m_reg[0]);
      chk("data_out", data_out, m_reg[2]);
      chk("pulse_count", pulse_cnt, exp_pulses);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] st, input int ar_dly, input int r_dly);
    int  r0;
    bit  done, hs;
    done = 0;
    exp_r.push_back(m_read(a, st));
    r0 = r_seen;
    status_in = st;
    for (int n = 0; n < 40 && !done; n++) begin
      if (n >= ar_dly) begin araddr = a; arvalid = 1'b1; end
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      if (hs) begin done = 1; arvalid = 1'b0; status_in = ~st; end
    end
    chk("ar_accept", done, 1);
    arvalid = 1'b0;
    repeat (r_dly) @(posedge clk);
    #1 rready = 1'b1;
    for (int n = 0; n < 40 && r_seen == r0; n++) begin @(posedge clk); #1; end
    rready = 1'b0;
    chk("r_done", r_seen != r0, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom_range(0, 15);
    if ($urandom_range(0, 9) == 0) a = a | (32'h10 << $urandom_range(0, 27));
    return a;
  endfunction

  initial begin
    int b0;
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 0);
    chk("rst_valid", {bvalid, rvalid, data_wr_pulse}, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_data", data_out, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;

    // strobe 0x5 into CTRL from zero
    do_write(32'h0, 32'hFFFF_FFFF, 4'h5, 0, 0, 0, 1);
    chk("ctrl_strb5", ctrl_out, 32'h00FF_00FF);
    // AW and W together to DATA, bvalid the cycle after the pulse
    do_write(32'h8, 32'h48, 4'hF, 0, 0, 0, 1);
    chk("data_48", data_out, 32'h48);
    chk("b_after_pulse", b_rise_cyc - pulse_cyc, 1);
    // W two cycles ahead of AW, read back
    do_write(32'hC, 32'hDEAD_BEEF, 4'hF, 2, 0, 1, 1);
    do_read(32'hC, 32'h0, 0, 0);
    // STATUS read with a stalled rready
    do_read(32'h4, 32'hA5, 0, 3);
    // Out of range, STATUS write, zero strobe on DATA, ignored offset bits
    do_write(32'h10, 32'h1234_5678, 4'hF, 0, 0, 0, 1);
    do_read(32'h10, 32'h0, 0, 0);
    do_write(32'h4, 32'h5555_5555, 4'hF, 1, 0, 0, 1);
    do_write(32'h8, 32'hFFFF_FFFF, 4'h0, 0, 1, 2, 1);
    do_write(32'h3, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1);
    do_read(32'hF, 32'h0, 1, 0);
    do_read(32'h0, 32'h0, 0, 1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1);
      else
        do_read(rand_addr(), $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // reset while a write response is pending
    do_write(32'h0, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
    for (int n = 0; n < 10 && !bvalid; n++) begin @(posedge clk); #1; end
    chk("pre_rst_bvalid", bvalid, 1);
    reset = 1'b1;
    #1;
    chk("rst_bvalid_drop", bvalid, 0);
    chk("rst_ready_mid", {awready, wready, arready}, 0);
    exp_b.delete();
    exp_r.delete();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    bready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    b0 = b_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("no_resp_after_rst", b_seen, b0);
    chk("ctrl_after_rst", ctrl_out, m_reg[0]);
    chk("ready_after_rst2", {awready, wready, arready}, 3'b111);
    bready = 1'b0;
    do_read(32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0", total);
    $fatal(1, "timeout");
  end

endmodule
